// File: rtl/tmds_encoder_if.sv
// TMDS encoder lane bus.
// Pixel/control inputs and the encoded 10-bit symbol.
interface tmds_encoder_if;
    logic [7:0] data_i;
    logic [1:0] ctrl_i;
    logic       blank_i;
    logic [9:0] symbol_o;

    modport master (
        output data_i,
        output ctrl_i,
        output blank_i,
        input  symbol_o
    );

    modport slave (
        input  data_i,
        input  ctrl_i,
        input  blank_i,
        output symbol_o
    );
endinterface

// File: rtl/tmds_encoder.sv
// TMDS 8b/10b lane encoder, two register stages.
// Stage 1 minimises transitions, stage 2 balances DC.
module tmds_encoder #(
    parameter bit INVERT_OUT = 1'b0
) (
    input  logic           clk_i,
    input  logic           rst_i,
    tmds_encoder_if.slave  bus
);

    typedef struct packed {
        logic       blank;
        logic [1:0] ctrl;
        logic [8:0] qm;
    } s1_t;

    localparam logic [9:0] CTRL_00 = 10'h354;
    localparam logic [9:0] CTRL_01 = 10'h0AB;
    localparam logic [9:0] CTRL_10 = 10'h154;
    localparam logic [9:0] CTRL_11 = 10'h2AB;
    localparam logic [9:0] OUT_MASK = {10{INVERT_OUT}};

    function automatic logic [3:0] pop8(logic [7:0] v);
        logic [3:0] s;
        s = '0;
        for (int i = 0; i < 8; i++) begin
            s = s + {3'b000, v[i]};
        end
        return s;
    endfunction

    function automatic logic [8:0] minimise(logic [7:0] d);
        logic [8:0] q;
        logic [3:0] n1;
        logic       xm;
        n1 = pop8(d);
        xm = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
        q = '0;
        q[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = xm ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~xm;
        return q;
    endfunction

    s1_t s1_d;
    s1_t s1_q;

    logic signed [4:0] cnt;
    logic signed [4:0] cnt_d;
    logic        [9:0] sym_d;
    logic        [9:0] sym_q;

    logic        [3:0] n1q;
    logic        [5:0] d6;
    logic signed [4:0] diff;
    logic signed [4:0] two_q8;
    logic signed [4:0] two_nq8;
    logic              q8;
    logic              neutral;
    logic              invert;

    // Stage 1 input: sample controls and build the minimised word.
    always_comb begin
        s1_d       = '0;
        s1_d.blank = bus.blank_i;
        s1_d.ctrl  = bus.ctrl_i;
        s1_d.qm    = minimise(bus.data_i);
    end

    // Stage 1 register; reset presents a blanking control 00.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            s1_q.blank <= 1'b1;
            s1_q.ctrl  <= 2'b00;
            s1_q.qm    <= '0;
        end else begin
            s1_q <= s1_d;
        end
    end

    // Stage 2 decision: control symbol or DC-balanced data symbol.
    always_comb begin
        n1q     = pop8(s1_q.qm[7:0]);
        d6      = {1'b0, n1q, 1'b0} - 6'd8;
        diff    = d6[4:0];
        q8      = s1_q.qm[8];
        two_q8  = {3'b000, q8, 1'b0};
        two_nq8 = {3'b000, ~q8, 1'b0};
        neutral = (cnt == 5'sd0) || (n1q == 4'd4);
        invert  = (!cnt[4] && (cnt != 5'sd0) && (n1q > 4'd4))
               || (cnt[4] && (n1q < 4'd4));
        sym_d   = CTRL_00;
        cnt_d   = cnt;
        unique case (1'b1)
            s1_q.blank: begin
                cnt_d = '0;
                unique case (s1_q.ctrl)
                    2'b00:   sym_d = CTRL_00;
                    2'b01:   sym_d = CTRL_01;
                    2'b10:   sym_d = CTRL_10;
                    default: sym_d = CTRL_11;
                endcase
            end
            (!s1_q.blank && neutral): begin
                sym_d = {~q8, q8,
                         q8 ? s1_q.qm[7:0] : ~s1_q.qm[7:0]};
                cnt_d = q8 ? cnt + diff : cnt - diff;
            end
            (!s1_q.blank && invert): begin
                sym_d = {1'b1, q8, ~s1_q.qm[7:0]};
                cnt_d = cnt + two_q8 - diff;
            end
            default: begin
                sym_d = {1'b0, q8, s1_q.qm[7:0]};
                cnt_d = cnt + diff - two_nq8;
            end
        endcase
    end

    // Stage 2 register; lane polarity applied only on the output.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt   <= '0;
            sym_q <= CTRL_00 ^ OUT_MASK;
        end else begin
            cnt   <= cnt_d;
            sym_q <= sym_d ^ OUT_MASK;
        end
    end

    assign bus.symbol_o = sym_q;

endmodule

// File: tb/tb_tmds_encoder.sv
// Bench for tmds_encoder: vector table, reset cases,
// and a random stream scored against a reference model.
module tb_tmds_encoder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    tmds_encoder_if bus0 ();
    tmds_encoder_if bus1 ();

    tmds_encoder #(.INVERT_OUT(1'b0)) dut0 (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus0)
    );

    tmds_encoder #(.INVERT_OUT(1'b1)) dut1 (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus1)
    );

    typedef struct {
        bit       blank;
        bit [1:0] ctrl;
        bit [7:0] data;
        bit       chk;
        bit [9:0] sym;
        int       cnt;
    } item_t;

    typedef struct {
        bit       blank;
        bit [1:0] ctrl;
        bit [7:0] data;
        bit [9:0] sym;
        int       cnt;
    } tv_t;

    item_t sb[$];
    tv_t   tbl[10];
    int    checks = 0;
    int    errors = 0;
    int    mcnt = 0;
    int    acc = 0;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d",
                     name, act, exp);
        end
    endtask

    task automatic drive(bit b, bit [1:0] c, bit [7:0] d);
        bus0.blank_i = b;
        bus0.ctrl_i  = c;
        bus0.data_i  = d;
        bus1.blank_i = b;
        bus1.ctrl_i  = c;
        bus1.data_i  = d;
    endtask

    task automatic pop_check();
        item_t    e;
        bit [9:0] inv;
        int       c0;
        if (sb.size() >= 2) begin
            e = sb.pop_front();
            if (e.chk) begin
                inv = ~e.sym;
                c0  = int'(dut0.cnt);
                check("sym", int'(bus0.symbol_o), int'(e.sym));
                check("sym_inv", int'(bus1.symbol_o), int'(inv));
                check("cnt", c0, e.cnt);
                check("cnt_inv", int'(dut1.cnt), e.cnt);
                check("cnt_bound", int'(c0 >= -10 && c0 <= 10), 1);
                if (e.blank) begin
                    acc = 0;
                end else begin
                    acc += 2 * $countones(bus0.symbol_o) - 10;
                    check("disparity", acc, e.cnt);
                end
            end
        end
    endtask

    task automatic cyc(bit b, bit [1:0] c, bit [7:0] d,
                       bit chk, bit [9:0] es, int ec);
        item_t e;
        @(negedge clk);
        pop_check();
        drive(b, c, d);
        e = '{b, c, d, chk, es, ec};
        sb.push_back(e);
    endtask

    function automatic bit [9:0] model(bit b, bit [1:0] c,
                                       bit [7:0] d);
        bit [8:0] q;
        bit [9:0] s;
        int       n1;
        int       n1q;
        int       n0q;
        bit       xm;
        if (b) begin
            mcnt = 0;
            case (c)
                2'b00:   s = 10'h354;
                2'b01:   s = 10'h0AB;
                2'b10:   s = 10'h154;
                default: s = 10'h2AB;
            endcase
            return s;
        end
        n1 = $countones(d);
        xm = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
        q = '0;
        q[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = xm ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = !xm;
        n1q = $countones(q[7:0]);
        n0q = 8 - n1q;
        if (mcnt == 0 || n1q == n0q) begin
            s = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
            mcnt += q[8] ? (n1q - n0q) : (n0q - n1q);
        end else if ((mcnt > 0 && n1q > n0q) ||
                     (mcnt < 0 && n0q > n1q)) begin
            s = {1'b1, q[8], ~q[7:0]};
            mcnt += (q[8] ? 2 : 0) + n0q - n1q;
        end else begin
            s = {1'b0, q[8], q[7:0]};
            mcnt += n1q - n0q - (q[8] ? 0 : 2);
        end
        return s;
    endfunction

    initial begin
        item_t    e;
        bit       b;
        bit [1:0] c;
        bit [7:0] d;
        bit [9:0] s;

        tbl[0] = '{1'b1, 2'b00, 8'h00, 10'h354, 0};
        tbl[1] = '{1'b1, 2'b01, 8'h00, 10'h0AB, 0};
        tbl[2] = '{1'b1, 2'b10, 8'h00, 10'h154, 0};
        tbl[3] = '{1'b1, 2'b11, 8'h00, 10'h2AB, 0};
        tbl[4] = '{1'b0, 2'b00, 8'h00, 10'h100, -8};
        tbl[5] = '{1'b0, 2'b00, 8'h00, 10'h3FF, 2};
        tbl[6] = '{1'b0, 2'b00, 8'h00, 10'h100, -6};
        tbl[7] = '{1'b1, 2'b00, 8'h00, 10'h354, 0};
        tbl[8] = '{1'b0, 2'b00, 8'hFF, 10'h200, -8};
        tbl[9] = '{1'b1, 2'b00, 8'h00, 10'h354, 0};

        drive(1'b0, 2'b11, 8'hA5);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sym", int'(bus0.symbol_o), 'h354);
        check("rst_sym_inv", int'(bus1.symbol_o), 'h0AB);
        check("rst_cnt", int'(dut0.cnt), 0);
        drive(1'b1, 2'b00, 8'h00);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].blank, tbl[i].ctrl, tbl[i].data,
                1'b1, tbl[i].sym, tbl[i].cnt);
        end

        cyc(1'b1, 2'b00, 8'h00, 1'b1, 10'h354, 0);
        cyc(1'b0, 2'b00, 8'h00, 1'b1, 10'h100, -8);
        cyc(1'b0, 2'b00, 8'h00, 1'b1, 10'h3FF, 2);
        cyc(1'b0, 2'b00, 8'h55, 1'b0, 10'h000, 0);
        @(negedge clk);
        pop_check();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_sym", int'(bus0.symbol_o), 'h354);
        check("midrst_sym_inv", int'(bus1.symbol_o), 'h0AB);
        check("midrst_cnt", int'(dut0.cnt), 0);
        sb.delete();
        acc = 0;
        @(negedge clk);
        drive(1'b1, 2'b00, 8'h00);
        rst_n = 1'b1;
        e = '{1'b1, 2'b00, 8'h00, 1'b0, 10'h000, 0};
        sb.push_back(e);
        cyc(1'b0, 2'b00, 8'h00, 1'b1, 10'h100, -8);

        for (int i = 0; i < 600; i++) begin
            b = (i == 0) || ($urandom_range(0, 15) == 0);
            c = 2'($urandom_range(0, 3));
            d = 8'($urandom_range(0, 255));
            s = model(b, c, d);
            cyc(b, c, d, 1'b1, s, mcnt);
        end

        cyc(1'b1, 2'b00, 8'h00, 1'b0, 10'h000, 0);
        cyc(1'b1, 2'b00, 8'h00, 1'b0, 10'h000, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tmds_encoder.md
TMDS_ENCODER -- requirements
Module: tmds_encoder

Interface
REQ-001 Parameter INVERT_OUT, default 0: when 1, symbol_o SHALL be the bitwise inverse of the encoded symbol, for lane polarity swap.
REQ-002 clk_i  input  1  pixel clock; all state SHALL be on its rising edge.
REQ-003 rst_i  input  1  reset; asynchronous, active-low.
REQ-004 data_i  input  8  pixel colour component (red, green or blue).
REQ-005 ctrl_i  input  2  control bits {c1,c0}; on the blue lane these are {vsync,hsync}, otherwise 0.
REQ-006 blank_i  input  1  1 = blanking interval (send control symbol); 0 = active video (send data symbol).
REQ-007 symbol_o  output  10  registered TMDS symbol; bit 0 is transmitted first by the downstream serialiser.

Function
REQ-008 The pipeline SHALL have two register stages, so inputs sampled at edge N appear on symbol_o after edge N+2.
REQ-009 Stage 1 SHALL register blank_i, ctrl_i and the 9-bit transition-minimised word q_m derived from data_i.
REQ-010 q_m derivation SHALL follow these rules:
- n1 = popcount(data_i).
- XNOR mode applies when n1>4, or when n1==4 and data_i[0]==0; otherwise XOR mode.
- q_m[0] = data_i[0].
- For i=1..7: q_m[i] = q_m[i-1] XOR data_i[i] (XOR mode), or XNOR data_i[i] (XNOR mode).
- q_m[8] = 1 in XOR mode, 0 in XNOR mode.
REQ-011 Stage 2 SHALL compute n1q = popcount(q_m[7:0]) and n0q = 8 - n1q, and SHALL hold a running disparity cnt as a 5-bit signed register.
REQ-012 Blanking (blank=1): symbol SHALL be selected from ctrl:
- 00 -> 0x354
- 01 -> 0x0AB
- 10 -> 0x154
- 11 -> 0x2AB
- cnt SHALL be cleared to 0.
REQ-013 Active, neutral case (cnt==0 or n1q==n0q):
- symbol = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
- cnt += q_m[8] ? (n1q-n0q) : (n0q-n1q).
REQ-014 Active, invert case ((cnt>0 and n1q>n0q) or (cnt<0 and n0q>n1q)):
- symbol = {1, q_m[8], ~q_m[7:0]}.
- cnt += 2*q_m[8] + (n0q-n1q).
REQ-015 Active, all other cases:
- symbol = {0, q_m[8], q_m[7:0]}.
- cnt += (n1q-n0q) - 2*(~q_m[8]).
REQ-016 cnt arithmetic SHALL be signed 5-bit; legal streams keep |cnt| ≤ 10, so no saturation logic is required.
REQ-017 A transition of blank_i SHALL take effect on symbol_o exactly two cycles later, aligned with the data, with no extra cycle.
REQ-018 INVERT_OUT SHALL be applied at the stage-2 output register only; cnt SHALL NOT depend on it.

Reset
REQ-019 While rst_i=0, the following SHALL hold:
- stage-1 blank = 1, ctrl = 00, q_m = 0.
- cnt = 0.
- symbol_o = 0x354, or 0x0AB when INVERT_OUT=1.
REQ-020 Reset SHALL take effect immediately on assertion, independent of clk_i.
REQ-021 After rst_i rises, the first sampled input SHALL appear at the 2nd following edge.
REQ-022 Asserting reset mid-stream SHALL discard in-flight stage-1 data and clear disparity.

Verification
REQ-023 Reset, INVERT_OUT=0: hold rst_i=0 -> symbol_o=0x354. Repeat with INVERT_OUT=1 -> symbol_o=0x0AB.
REQ-024 blank_i=1 with ctrl_i=00,01,10,11 on successive cycles -> symbol_o=0x354,0x0AB,0x154,0x2AB, starting two cycles later.
REQ-025 After blanking, data_i=0x00 for 3 cycles with blank_i=0 -> symbol_o=0x100,0x3FF,0x100; internal cnt = -8, +2, -6.
REQ-026 After blanking, data_i=0xFF for one cycle -> symbol_o=0x200 and cnt=-8; then blank_i=1, ctrl=00 -> 0x354 and cnt=0.
REQ-027 Mid-stream reset after the 0x00,0x00 pair (cnt=+2), then release and send 0x00 -> symbol_o=0x100, proving cnt was cleared.
REQ-028 Random data/blank stream against a reference model of REQ-010..REQ-015:
- every symbol SHALL match the model.
- |cnt| ≤ 10 at all times.
- over any active run, the symbol ones-count minus zeros-count accumulated SHALL equal the modelled cnt.
